// File: rtl/hm_pkg.sv
// Shared types and constants for the Hamming(7,4) serial receiver.
// HM_RX_SECDED_EN widens the frame to 8 bits (extra overall-parity bit).
package hm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } rx_state_t;

`ifdef HM_RX_SECDED_EN
  localparam int CW_LEN = 8;
`else
  localparam int CW_LEN = 7;
`endif
  localparam int INFO_LEN = 4;
  localparam int HAM_LEN  = 7;
  localparam int SYN_W    = 3;

  // A nonzero syndrome S points at codeword bit S-1.
  localparam int SYN_IDX_OFFSET = 1;

  // Systematic bit positions inside r0..r6.
  localparam int D0_IDX = 2;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  function automatic logic [HAM_LEN-1:0] syn_flip_mask(input logic [SYN_W-1:0] syn);
    if (syn == '0) begin
      syn_flip_mask = '0;
    end else begin
      syn_flip_mask = HAM_LEN'(1) << (syn - SYN_W'(SYN_IDX_OFFSET));
    end
  endfunction

endpackage

// File: rtl/hm_syndrome_corr.sv
// Combinational Hamming(7,4) syndrome decode and single-bit correction.
// With an 8-bit codeword the top bit is overall parity (SECDED).
module hm_syndrome_corr
  import hm_pkg::*;
#(
  parameter int CW_BITS = CW_LEN
) (
  input  logic [CW_BITS-1:0]  cw,
  output logic [INFO_LEN-1:0] data,
  output logic                corrected,
  output logic                uncorrectable
);

  logic [SYN_W-1:0]   syn;
  logic [HAM_LEN-1:0] ham;
  logic [HAM_LEN-1:0] fixed;
  logic               par;

  always_comb begin
    ham = cw[HAM_LEN-1:0];
    syn = {ham[3] ^ ham[4] ^ ham[5] ^ ham[6],
           ham[1] ^ ham[2] ^ ham[5] ^ ham[6],
           ham[0] ^ ham[2] ^ ham[4] ^ ham[6]};
    par           = ^cw;
    fixed         = ham;
    corrected     = 1'b0;
    uncorrectable = 1'b0;
    if (CW_BITS > HAM_LEN) begin
      if (syn != '0 && par) begin
        fixed     = ham ^ syn_flip_mask(syn);
        corrected = 1'b1;
      end else if (syn == '0 && par) begin
        // Only the parity bit itself was hit; the payload is intact.
        corrected = 1'b1;
      end else if (syn != '0) begin
        uncorrectable = 1'b1;
      end
    end else if (syn != '0) begin
      fixed     = ham ^ syn_flip_mask(syn);
      corrected = 1'b1;
    end
    data = {fixed[D3_IDX], fixed[D2_IDX], fixed[D1_IDX], fixed[D0_IDX]};
  end

endmodule

// File: rtl/hm_serial_rx.sv
// Bit-serial Hamming(7,4) receiver: start/codeword/stop framing, correction,
// valid/ready output. Define HM_RX_SECDED_EN for 8-bit SECDED frames.
module hm_serial_rx
  import hm_pkg::*;
#(
  parameter logic IDLE_LVL = 1'b1,
  parameter int   CW_BITS  = CW_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic                rx_line,
  output logic [INFO_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_corrected,
  output logic                frame_err,
  output logic                overflow
`ifdef HM_RX_SECDED_EN
  ,
  output logic                out_uncorrectable
`endif
);

  localparam logic [3:0] LAST_BIT = 4'(CW_BITS - 1);

  rx_state_t           state;
  logic [CW_BITS-1:0]  shreg;
  logic [3:0]          cnt;

  logic [INFO_LEN-1:0] dec_data;
  logic                dec_corr;
  logic                dec_uncorr;

  hm_syndrome_corr #(
    .CW_BITS(CW_BITS)
  ) u_corr (
    .cw           (shreg),
    .data         (dec_data),
    .corrected    (dec_corr),
    .uncorrectable(dec_uncorr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      cnt           <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_corrected <= 1'b0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
`ifdef HM_RX_SECDED_EN
      out_uncorrectable <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (sample_en) begin
        case (state)
          IDLE: begin
            if (rx_line != IDLE_LVL) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            // r0 arrives first and ends up in bit 0 after the last shift.
            shreg <= {rx_line, shreg[CW_BITS-1:1]};
            if (cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          STOP: begin
            if (rx_line == IDLE_LVL) begin
              state <= IDLE;
              // A same-cycle accept frees the slot, so the new word may load.
              if (!out_valid || out_ready) begin
                out_data      <= dec_data;
                out_corrected <= dec_corr & ~dec_uncorr;
                out_valid     <= 1'b1;
`ifdef HM_RX_SECDED_EN
                out_uncorrectable <= dec_uncorr;
`endif
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
          BREAK: begin
            if (rx_line == IDLE_LVL) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hm_serial_rx.sv
// Directed bench for hm_serial_rx; also covers HM_RX_SECDED_EN when defined.
module tb_hm_serial_rx;

`ifdef HM_RX_SECDED_EN
  localparam int CWB = 8;
`else
  localparam int CWB = 7;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic       rx_line;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_corrected;
  logic       frame_err;
  logic       overflow;
`ifdef HM_RX_SECDED_EN
  logic       out_uncorrectable;
`endif

  int checks = 0;
  int errors = 0;
  bit slow   = 1'b0;

  always #5 clk = ~clk;

  hm_serial_rx dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .rx_line      (rx_line),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_corrected(out_corrected),
    .frame_err    (frame_err),
    .overflow     (overflow)
`ifdef HM_RX_SECDED_EN
    ,
    .out_uncorrectable(out_uncorrectable)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In slow mode the strobe is high only on the last of every four cycles.
  task automatic send_bit(input logic b);
    rx_line = b;
    if (slow) begin
      sample_en = 1'b0;
      repeat (3) tick();
    end
    sample_en = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [6:0] cw, input logic r7, input logic stop,
                            input logic rdy_stop);
    logic [7:0] f;
    f = {r7, cw};
    send_bit(1'b0);
    for (int i = 0; i < CWB; i++) send_bit(f[i]);
    out_ready = rdy_stop;
    send_bit(stop);
    out_ready = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    sample_en = 1'b0;
    rx_line   = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_data", {4'd0, out_data}, 8'd0);
    chk("rst_corr", {7'd0, out_corrected}, 8'd0);
    chk("rst_ferr", {7'd0, frame_err}, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
`ifdef HM_RX_SECDED_EN
    chk("rst_uncorr", {7'd0, out_uncorrectable}, 8'd0);
`endif
    rst = 1'b0;
    idle(2);

    // Clean frame for 1011.
    send_frame(7'b1010101, 1'b0, 1'b1, 1'b0);
    chk("clean_valid", {7'd0, out_valid}, 8'd1);
    chk("clean_data", {4'd0, out_data}, 8'hb);
    chk("clean_corr", {7'd0, out_corrected}, 8'd0);
    chk("clean_ferr", {7'd0, frame_err}, 8'd0);
    accept();
    chk("accept_clr", {7'd0, out_valid}, 8'd0);

    // r4 flipped: S=5.
    send_frame(7'b1000101, 1'b0, 1'b1, 1'b0);
    chk("r4err_valid", {7'd0, out_valid}, 8'd1);
    chk("r4err_data", {4'd0, out_data}, 8'hb);
    chk("r4err_corr", {7'd0, out_corrected}, 8'd1);
    accept();

    // Bad stop bit, line stuck low, then recover.
    send_frame(7'b1010101, 1'b0, 1'b0, 1'b0);
    chk("badstop_ferr", {7'd0, frame_err}, 8'd1);
    chk("badstop_valid", {7'd0, out_valid}, 8'd0);
    send_bit(1'b0);
    chk("ferr_pulse", {7'd0, frame_err}, 8'd0);
    repeat (4) send_bit(1'b0);
    chk("break_valid", {7'd0, out_valid}, 8'd0);
    idle(2);
    chk("break_ferr", {7'd0, frame_err}, 8'd0);
    send_frame(7'b0110011, 1'b0, 1'b1, 1'b0);
    chk("recover_valid", {7'd0, out_valid}, 8'd1);
    chk("recover_data", {4'd0, out_data}, 8'h6);
    accept();

    // Overflow with out_ready low, then accept on the completion cycle.
    send_frame(7'b0000111, 1'b1, 1'b1, 1'b0);
    chk("ovf_first_data", {4'd0, out_data}, 8'h1);
    send_frame(7'b1111000, 1'b0, 1'b1, 1'b0);
    chk("ovf_pulse", {7'd0, overflow}, 8'd1);
    chk("ovf_valid", {7'd0, out_valid}, 8'd1);
    chk("ovf_held", {4'd0, out_data}, 8'h1);
    chk("ovf_no_ferr", {7'd0, frame_err}, 8'd0);
    tick();
    chk("ovf_one_cycle", {7'd0, overflow}, 8'd0);
    send_frame(7'b0110011, 1'b0, 1'b1, 1'b1);
    chk("swap_valid", {7'd0, out_valid}, 8'd1);
    chk("swap_data", {4'd0, out_data}, 8'h6);
    chk("swap_no_ovf", {7'd0, overflow}, 8'd0);
    accept();
    chk("swap_accept", {7'd0, out_valid}, 8'd0);

    // Reset after start + 3 data bits, fast then 1-in-4 strobe.
    for (int pass = 0; pass < 2; pass++) begin
      slow = (pass == 1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_valid", {7'd0, out_valid}, 8'd0);
      idle(1);
      send_frame(7'b0110011, 1'b0, 1'b1, 1'b0);
      chk("midrst_out_valid", {7'd0, out_valid}, 8'd1);
      chk("midrst_data", {4'd0, out_data}, 8'h6);
      chk("midrst_corr", {7'd0, out_corrected}, 8'd0);
      accept();
    end
    slow = 1'b0;

`ifdef HM_RX_SECDED_EN
    // 1011 with r1 and r5 flipped: detected, not corrected.
    send_frame(7'b1110111, 1'b0, 1'b1, 1'b0);
    chk("ded_valid", {7'd0, out_valid}, 8'd1);
    chk("ded_uncorr", {7'd0, out_uncorrectable}, 8'd1);
    chk("ded_corr", {7'd0, out_corrected}, 8'd0);
    chk("ded_data", {4'd0, out_data}, 8'hf);
    accept();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
